// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
// Serial sequence detector. It shifts in one bit on each enabled clock and
// compares the last N bits against NPAT patterns that can be reloaded at
// runtime. Outputs are a registered per-pattern match pulse, sticky flags,
// a saturating match counter and the number of valid history bits.
//
// Handshake/strobe semantics: there is no backpressure. A bit on w is
// consumed on every rising clock edge where enable=1, pat_load=0 and
// reset=0. If pat_load is high, the concurrent sample is dropped.
// Priority is reset > pat_load > enable. clr_count is independent of the
// sample path: a hit on the same edge is recorded after the clear.
module seq_pattern_detector #(
    parameter int                 N        = 4,
    parameter int                 NPAT     = 2,
    parameter int                 CNT_W    = 8,
    parameter logic [N*NPAT-1:0]  PAT_INIT = {4'b1101, 4'b1111}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     w,
    input  logic                     overlap,
    input  logic                     pat_load,
    input  logic [N*NPAT-1:0]        pat_in,
    input  logic                     clr_count,
    output logic [NPAT-1:0]          match,
    output logic                     any_match,
    output logic [NPAT-1:0]          sticky,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(N+1)-1:0]   fill
);

    localparam int                  FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(N);
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

    // History register: hist_q[0] is the newest bit, hist_q[N-1] the oldest.
    logic [N-1:0]         hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_inc;
    logic [NPAT-1:0]      match_q, match_d;
    logic [NPAT-1:0]      sticky_q, sticky_d, sticky_base;
    logic [CNT_W-1:0]     count_q, count_d, count_base;
    logic [N*NPAT-1:0]    pat_q, pat_d;
    logic [NPAT-1:0]      hit;
    logic                 sample;

    // Look at the window the current sample would produce and compare it
    // against every pattern. A hit needs N valid bits in that window.
    always_comb begin
        sample     = enable && !pat_load;
        hist_shift = {hist_q[N-2:0], w};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        hit        = '0;
        for (int i = 0; i < NPAT; i++) begin
            hit[i] = sample && (fill_inc == FILL_FULL) &&
                     (hist_shift == pat_q[i*N +: N]);
        end
    end

    // Next state for history, fill level, pattern bank and match pulse.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        match_d = '0;
        if (pat_load) begin
            // A new pattern bank invalidates the window collected so far.
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (enable) begin
            hist_d  = hist_shift;
            match_d = hit;
            // In non-overlapping mode a hit consumes the window, so the
            // next match needs N fresh samples. hist still shifts.
            if ((|hit) && !overlap) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    // Counter and sticky flags: apply the clear first, then record any hit.
    always_comb begin
        count_base  = clr_count ? '0 : count_q;
        sticky_base = clr_count ? '0 : sticky_q;
        count_d     = count_base;
        sticky_d    = sticky_base | hit;
        // Count one per sample, even when several patterns hit together.
        if ((|hit) && (count_base != CNT_MAX)) begin
            count_d = count_base + CNT_W'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q   <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            pat_q    <= PAT_INIT;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            pat_q    <= pat_d;
        end
    end

    assign match       = match_q;
    assign any_match   = |match_q;
    assign sticky      = sticky_q;
    assign match_count = count_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Testbench for seq_pattern_detector. It drives two instances from the same
// stimulus: the default configuration and one with a 2-bit counter that
// shows saturation. The test has directed vector tables, hand sequences
// and random traffic checked against a queue-based reference model.
module tb_seq_pattern_detector;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset, enable, w, overlap, pat_load, clr_count;
  logic [7:0] pat_in;
  logic [1:0] match, match_s, sticky, sticky_s;
  logic       any_match, any_match_s;
  logic [7:0] match_count;
  logic [1:0] match_count_s;
  logic [2:0] fill, fill_s;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  seq_pattern_detector u_dut (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
    .match(match), .any_match(any_match), .sticky(sticky),
    .match_count(match_count), .fill(fill)
  );

  seq_pattern_detector #(.CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
    .match(match_s), .any_match(any_match_s), .sticky(sticky_s),
    .match_count(match_count_s), .fill(fill_s)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the last N sampled bits in arrival order and counts
  // samples since the window was last invalidated.
  localparam int MN = 4;
  int         m_bits[$];
  int         m_fresh  = 0;
  logic [7:0] m_pat    = 8'hDF;
  logic [1:0] m_match  = '0;
  logic [1:0] m_sticky = '0;
  int         m_cnt    = 0;
  int         m_cnt_s  = 0;

  task automatic model_edge(input logic rst, input logic en, input logic wb,
                            input logic ovl, input logic ld, input logic [7:0] pat,
                            input logic clr);
    logic [1:0] hitv;
    int val;
    hitv = '0;
    if (rst) begin
      m_bits.delete(); m_fresh = 0; m_pat = 8'hDF;
      m_match = '0; m_sticky = '0; m_cnt = 0; m_cnt_s = 0;
      return;
    end
    if (ld) begin
      m_pat = pat; m_bits.delete(); m_fresh = 0; m_match = '0;
    end else if (en) begin
      m_bits.push_back(int'(wb));
      if (m_bits.size() > MN) void'(m_bits.pop_front());
      if (m_fresh < MN) m_fresh++;
      val = 0;
      foreach (m_bits[k]) val = val * 2 + m_bits[k];
      for (int i = 0; i < 2; i++) begin
        if (m_fresh == MN && val == int'(m_pat[i*4 +: 4])) hitv[i] = 1'b1;
      end
      m_match = hitv;
      if (hitv != 0 && !ovl) m_fresh = 0;
    end else begin
      m_match = '0;
    end
    if (clr) begin
      m_cnt = 0; m_cnt_s = 0; m_sticky = '0;
    end
    if (hitv != 0) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
      m_sticky = m_sticky | hitv;
    end
  endtask

  task automatic compare_model();
    chk("model_match",       32'(match),         32'(m_match));
    chk("model_any_match",   32'(any_match),     32'(m_match != 0));
    chk("model_sticky",      32'(sticky),        32'(m_sticky));
    chk("model_fill",        32'(fill),          32'(m_fresh));
    chk("model_count",       32'(match_count),   32'(m_cnt));
    chk("model_count_sat",   32'(match_count_s), 32'(m_cnt_s));
  endtask

  // ---------------- driver ----------------
  // Inputs are applied away from the edge, the model advances on the edge,
  // and outputs are sampled 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic wb, input logic ovl,
                      input logic ld, input logic [7:0] pat, input logic clr);
    reset = rst; enable = en; w = wb; overlap = ovl;
    pat_load = ld; pat_in = pat; clr_count = clr;
    @(posedge clock);
    model_edge(rst, en, wb, ovl, ld, pat, clr);
    #1;
    compare_model();
  endtask

  task automatic samp(input logic wb, input logic ovl);
    step(1'b0, 1'b1, wb, ovl, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic reload(input logic [7:0] pat, input logic ovl);
    step(1'b0, 1'b1, 1'b1, ovl, 1'b1, pat, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic       w;
    logic       ovl;
    logic       ld;
    logic [7:0] pat;
    logic       clr;
    logic [1:0] exp_match;
    logic [2:0] exp_fill;
    logic [7:0] exp_cnt;
    logic [1:0] exp_sticky;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic wb, input logic ovl, input logic ld,
                     input logic [7:0] pat, input logic [1:0] em, input logic [2:0] ef,
                     input logic [7:0] ec, input logic [1:0] es);
    vec_t v;
    v.en = en; v.w = wb; v.ovl = ovl; v.ld = ld; v.pat = pat; v.clr = 1'b0;
    v.exp_match = em; v.exp_fill = ef; v.exp_cnt = ec; v.exp_sticky = es;
    vecs.push_back(v);
  endtask

  initial begin
    int base;
    int efill;
    logic [11:0] en_pat;

    reset = 1'b1; enable = 1'b1; w = 1'b1; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 8'h00; clr_count = 1'b0;

    // Overlapping detection with the reset patterns (1111, 1101).
    add(1,1,1,0,8'h00, 2'b00,3'd1,8'd0,2'b00);
    add(1,1,1,0,8'h00, 2'b00,3'd2,8'd0,2'b00);
    add(1,1,1,0,8'h00, 2'b00,3'd3,8'd0,2'b00);
    add(1,1,1,0,8'h00, 2'b01,3'd4,8'd1,2'b01);
    add(1,1,1,0,8'h00, 2'b01,3'd4,8'd2,2'b01);
    add(1,1,1,0,8'h00, 2'b01,3'd4,8'd3,2'b01);
    add(1,1,1,1,8'hDF, 2'b00,3'd0,8'd3,2'b01);
    add(1,1,1,0,8'h00, 2'b00,3'd1,8'd3,2'b01);
    add(1,1,1,0,8'h00, 2'b00,3'd2,8'd3,2'b01);
    add(1,0,1,0,8'h00, 2'b00,3'd3,8'd3,2'b01);
    add(1,1,1,0,8'h00, 2'b10,3'd4,8'd4,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd4,8'd4,2'b11);
    add(1,0,1,0,8'h00, 2'b00,3'd4,8'd4,2'b11);
    add(1,1,1,0,8'h00, 2'b10,3'd4,8'd5,2'b11);
    // Non-overlapping: eight 1s, then 1101101.
    add(1,1,0,1,8'hDF, 2'b00,3'd0,8'd5,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd1,8'd5,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd2,8'd5,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd3,8'd5,2'b11);
    add(1,1,0,0,8'h00, 2'b01,3'd0,8'd6,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd1,8'd6,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd2,8'd6,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd3,8'd6,2'b11);
    add(1,1,0,0,8'h00, 2'b01,3'd0,8'd7,2'b11);
    add(1,1,0,1,8'hDF, 2'b00,3'd0,8'd7,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd1,8'd7,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd2,8'd7,2'b11);
    add(1,0,0,0,8'h00, 2'b00,3'd3,8'd7,2'b11);
    add(1,1,0,0,8'h00, 2'b10,3'd0,8'd8,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd1,8'd8,2'b11);
    add(1,0,0,0,8'h00, 2'b00,3'd2,8'd8,2'b11);
    add(1,1,0,0,8'h00, 2'b00,3'd3,8'd8,2'b11);
    // Reload mid-stream after 1,1,1; the concurrent sample is dropped.
    add(1,1,1,1,8'hDF, 2'b00,3'd0,8'd8,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd1,8'd8,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd2,8'd8,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd3,8'd8,2'b11);
    add(1,1,1,1,8'h0A, 2'b00,3'd0,8'd8,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd1,8'd8,2'b11);
    add(1,0,1,0,8'h00, 2'b00,3'd2,8'd8,2'b11);
    add(1,1,1,0,8'h00, 2'b00,3'd3,8'd8,2'b11);
    add(1,0,1,0,8'h00, 2'b01,3'd4,8'd9,2'b11);

    // Reset defaults: two reset clocks with enable=1 and w=1.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_match",  32'(match),       32'd0);
    chk("reset_fill",   32'(fill),        32'd0);
    chk("reset_count",  32'(match_count), 32'd0);
    chk("reset_sticky", 32'(sticky),      32'd0);

    foreach (vecs[k]) begin
      step(1'b0, vecs[k].en, vecs[k].w, vecs[k].ovl, vecs[k].ld, vecs[k].pat, vecs[k].clr);
      chk($sformatf("vec%0d_match", k),  32'(match),       32'(vecs[k].exp_match));
      chk($sformatf("vec%0d_fill", k),   32'(fill),        32'(vecs[k].exp_fill));
      chk($sformatf("vec%0d_count", k),  32'(match_count), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d_sticky", k), 32'(sticky),      32'(vecs[k].exp_sticky));
    end

    // Identical patterns: both bits fire, counter advances by one.
    reload(8'hFF, 1'b1);
    base = m_cnt;
    repeat (4) samp(1'b1, 1'b1);
    chk("ident_match", 32'(match),       32'h3);
    chk("ident_count", 32'(match_count), 32'(base + 1));

    // Enable gating with w held at 1.
    reload(8'hDF, 1'b1);
    en_pat = 12'b100101101001;
    efill = 0;
    for (int i = 11; i >= 0; i--) begin
      step(1'b0, en_pat[i], 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      if (en_pat[i]) begin
        if (efill < 4) efill++;
      end else begin
        chk("gate_match_idle", 32'(match), 32'd0);
      end
      chk("gate_fill", 32'(fill), 32'(efill));
    end

    // Saturation: ten overlapping 1111 hits.
    reload(8'hDF, 1'b1);
    base = m_cnt;
    repeat (13) samp(1'b1, 1'b1);
    chk("sat_count_narrow", 32'(match_count_s), 32'd3);
    chk("sat_count_wide",   32'(match_count),   32'(base + 10));
    // Clear on the same edge as a hit: clear, then record the hit.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("clr_hit_count",        32'(match_count),   32'd1);
    chk("clr_hit_count_narrow", 32'(match_count_s), 32'd1);
    chk("clr_hit_sticky",       32'(sticky),        32'h1);

    // Reset mid-stream at fill=2.
    reload(8'h0A, 1'b1);
    samp(1'b1, 1'b1);
    samp(1'b1, 1'b1);
    chk("mid_fill_before", 32'(fill), 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_reset_fill",   32'(fill),        32'd0);
    chk("mid_reset_count",  32'(match_count), 32'd0);
    chk("mid_reset_sticky", 32'(sticky),      32'd0);
    chk("mid_reset_match",  32'(match),       32'd0);
    repeat (4) samp(1'b1, 1'b1);
    chk("mid_reset_patinit", 32'(match), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [7:0] rp;
      case ($urandom_range(0, 3))
        0: rp = 8'hDF;
        1: rp = 8'h0A;
        2: rp = 8'hFF;
        default: rp = 8'(($urandom_range(0, 255)));
      endcase
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0),
           rp,
           ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
